// File: rtl/serial_decomplement.sv
// Two's-complement to sign-magnitude converter, bit-serial LSB first (copy until first one, then invert).
// Define DECOMP_FAST_EN for a single-cycle parallel conversion (no SHIFT state, busy never asserted).
module serial_decomplement #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] iin,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             min_neg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          accept = 1'b1;
`ifdef DECOMP_FAST_EN
          state_nxt = DONE;
`else
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT: if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

`ifdef DECOMP_FAST_EN
  assign last = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign    <= 1'b0;
      mag     <= '0;
      min_neg <= 1'b0;
    end else if (accept) begin
      sign    <= iin[WIDTH-1];
      mag     <= iin[WIDTH-1] ? (~iin) + WIDTH'(1) : iin;
      min_neg <= (iin == MIN_VAL);
    end
  end
`else
  logic [WIDTH-1:0] shreg, acc, acc_nxt;
  logic [CW-1:0]    count;
  logic             neg, seen_one, bit_o;

  // Once the first one has passed, negative operands have every later bit inverted.
  assign bit_o   = (neg & seen_one) ? ~shreg[0] : shreg[0];
  assign acc_nxt = {bit_o, acc[WIDTH-1:1]};
  assign last    = (count == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      seen_one <= 1'b0;
      sign     <= 1'b0;
      mag      <= '0;
      min_neg  <= 1'b0;
    end else if (accept) begin
      shreg    <= iin;
      neg      <= iin[WIDTH-1];
      seen_one <= 1'b0;
      count    <= '0;
    end else if (state == SHIFT) begin
      shreg    <= shreg >> 1;
      acc      <= acc_nxt;
      seen_one <= seen_one | shreg[0];
      count    <= count + CW'(1);
      // Published outputs only move on the final shift so they hold through SHIFT.
      if (last) begin
        sign    <= neg;
        mag     <= acc_nxt;
        min_neg <= neg & (acc_nxt == MIN_VAL);
      end
    end
  end
`endif

endmodule
